branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

ID-stage branch resolution controller for the dynamic pipeline. It gathers the beq/bne operands from the register file or forwarding paths and stalls IF/ID while a producer is still in flight. Once the operands are ready it decides taken/not-taken, then issues a one-cycle PC redirect with IF/ID flush. It also keeps saturating branch performance counters.

## Interface
- `CNT_W`, 32, width of each performance counter.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ext_stall` in 1: global pipeline freeze; the block holds all state and counters.
- `id_valid` in 1: the ID stage holds a live instruction.
- `id_is_branch` in 1: the ID instruction is beq/bne.
- `id_cmp_equal` in 1: 1 = beq (taken when equal), 0 = bne (taken when not equal).
- `id_rs`, `id_rt` in 5: source register numbers.
- `id_pc` in 32: PC of the ID instruction.
- `id_imm` in 16: branch offset in words.
- `rf_rdata1`, `rf_rdata2` in 32: register-file read data for rs and rt.
- `ex_wr_en`, `mem_wr_en`, `wb_wr_en` in 1: each stage will write a register.
- `ex_wr_reg`, `mem_wr_reg`, `wb_wr_reg` in 5: destination register of each stage.
- `mem_is_load` in 1: the MEM-stage instruction is a load.
- `mem_result`, `wb_data` in 32: forwardable values.
- `stall_id` out 1: hold PC and IF/ID (combinational).
- `flush_id` out 1: load a bubble into IF/ID at the end of this cycle.
- `redirect_valid` out 1: load PC from `redirect_pc` at the end of this cycle.
- `redirect_pc` out 32: branch target.
- `perf_branches`, `perf_taken`, `perf_stall_cycles` out CNT_W: event counters.

## Operation
- States: IDLE, WAIT, REDIRECT.
- `br_req` = `id_valid & id_is_branch`.
- Operand select, applied to each of rs and rt, first match wins:
  - reg == 0: value 0, ready.
  - `ex_wr_en` and match: not ready.
  - `mem_wr_en` and match: not ready if `mem_is_load`, otherwise `mem_result`.
  - `wb_wr_en` and match: `wb_data`.
  - Otherwise: rf data.
- `ready` = both operands ready.
- `taken` = `id_cmp_equal ? (a==b) : (a!=b)`.
- Target = `id_pc + 4 + (sign_extend(id_imm) << 2)`, computed modulo 2^32 (wraps silently).
- IDLE:
  - `br_req & ~ready`: go to WAIT.
  - `br_req & ready & taken`: latch the target and go to REDIRECT.
  - Otherwise: stay in IDLE.
- WAIT: same decision as IDLE.
  - If `br_req` drops (external kill), return to IDLE with no redirect.
- REDIRECT: lasts exactly one cycle, then returns to IDLE.
  - `id_*` inputs are ignored; the ID slot holds the wrong-path instruction.
- `stall_id` = `(state != REDIRECT) & br_req & ~ready & rst_n`.
- `flush_id` = `redirect_valid` = (state == REDIRECT).
- `ext_stall`=1 freezes everything:
  - No state transition, no latch, no counter increment.
  - Outputs keep driving their current values.
- Counters, each saturating at all-ones:
  - `perf_branches` +1 per decision (taken or not).
  - `perf_taken` +1 per taken decision.
  - `perf_stall_cycles` +1 per cycle with `stall_id`=1 and `ext_stall`=0.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - `redirect_pc`=0 and all counters = 0.
  - `stall_id`, `flush_id` and `redirect_valid` read 0 while `rst_n`=0.
  - A reset during WAIT or REDIRECT abandons the branch; no redirect is emitted.
- Decision latency:
  - Decision in cycle N when operands are ready.
  - `redirect_valid` and `flush_id` are high in cycle N+1 only.
  - Taken-branch penalty is 2 cycles (fall-through and next fetch squashed).
- Not-taken branches cost 0 cycles and produce no output pulse.
- Stall length:
  - EX-stage producer: 1 cycle minimum.
  - MEM-stage load: 1 cycle.
  - EX-stage load: 2 cycles.
- rs == rt with a pending producer: a single hazard, same stall length.

## Structure
- Shared package `pipe_pkg`:
  - State enum `br_state_t`.
  - `REG_ZERO` = 5'd0.
  - `BR_OFS_SHIFT` = 2.
- Sub-module `branch_fwd_sel`:
  - Purely combinational operand selection for one source register.
  - Instantiated twice (rs, rt); outputs value + ready.
- Comparison, state machine, target register and counters live in the top module.

## Test plan
- beq r1,r2 with r1=r2=0x5, no hazards, `id_pc`=0x100, imm=0x3: N+1 `redirect_valid`=1, `redirect_pc`=0x110; `perf_taken`=1.
- bne with equal operands: no stall, no redirect; `perf_branches`+1, `perf_taken` unchanged.
- beq whose rs is written by a load in EX: `stall_id` high 2 cycles, then decision; `perf_stall_cycles`=2.
- `ext_stall` held 3 cycles during WAIT: state, `stall_id` and counters frozen; resumes identically afterwards.
- `rst_n`=0 during REDIRECT: next cycle all outputs and counters 0, state IDLE.
- imm=0x8000 with `id_pc`=0x10: `redirect_pc`=0xFFFE0014 (wrap); counter preset near all-ones saturates without wrapping.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID-stage branch resolution logic.
// Holds the resolver state encoding and the branch target arithmetic.
package pipe_pkg;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_WAIT     = 2'd1,
    BR_REDIRECT = 2'd2
  } br_state_t;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         BR_OFS_SHIFT = 2;

  // Word offset relative to the fall-through PC; wraps modulo 2^32.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    logic [31:0] ofs;
    ofs = {{16{imm[15]}}, imm} << BR_OFS_SHIFT;
    return pc + 32'd4 + ofs;
  endfunction

endpackage

// File: rtl/branch_fwd_sel.sv
// Operand source select for one branch register: zero reg, EX/MEM/WB forward or RF.
// Combinational, 0 cycles; ready=0 means the producer has not yet produced the value.
module branch_fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0]  src_reg,
  input  logic [31:0] rf_rdata,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_reg,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_reg,
  input  logic        mem_is_load,
  input  logic [31:0] mem_result,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_reg,
  input  logic [31:0] wb_data,
  output logic [31:0] value,
  output logic        ready
);

  // Youngest producer wins; an EX result or a MEM load is not available at ID yet.
  always_comb begin
    value = rf_rdata;
    ready = 1'b1;
    if (src_reg == REG_ZERO) begin
      value = 32'd0;
    end else if (ex_wr_en && (ex_wr_reg == src_reg)) begin
      ready = 1'b0;
    end else if (mem_wr_en && (mem_wr_reg == src_reg)) begin
      value = mem_result;
      ready = ~mem_is_load;
    end else if (wb_wr_en && (wb_wr_reg == src_reg)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves beq/bne in ID: stalls on in-flight producers, redirects PC one cycle after a taken decision.
// ext_stall freezes state, target and counters; stall_id is combinational from current inputs.
module branch_resolve_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic             id_cmp_equal,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  input  logic             ex_wr_en,
  input  logic             mem_wr_en,
  input  logic             wb_wr_en,
  input  logic [4:0]       ex_wr_reg,
  input  logic [4:0]       mem_wr_reg,
  input  logic [4:0]       wb_wr_reg,
  input  logic             mem_is_load,
  input  logic [31:0]      mem_result,
  input  logic [31:0]      wb_data,
  output logic             stall_id,
  output logic             flush_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken,
  output logic [CNT_W-1:0] perf_stall_cycles
);

  br_state_t   state;
  logic [31:0] a_val, b_val;
  logic        a_rdy, b_rdy;
  logic        br_req, ready, taken, decide;

  branch_fwd_sel u_sel_rs (
    .src_reg     (id_rs),
    .rf_rdata    (rf_rdata1),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_reg   (ex_wr_reg),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_reg  (mem_wr_reg),
    .mem_is_load (mem_is_load),
    .mem_result  (mem_result),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_reg   (wb_wr_reg),
    .wb_data     (wb_data),
    .value       (a_val),
    .ready       (a_rdy)
  );

  branch_fwd_sel u_sel_rt (
    .src_reg     (id_rt),
    .rf_rdata    (rf_rdata2),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_reg   (ex_wr_reg),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_reg  (mem_wr_reg),
    .mem_is_load (mem_is_load),
    .mem_result  (mem_result),
    .wb_wr_en    (wb_wr_en),
    .wb_wr_reg   (wb_wr_reg),
    .wb_data     (wb_data),
    .value       (b_val),
    .ready       (b_rdy)
  );

  assign br_req = id_valid & id_is_branch;
  assign ready  = a_rdy & b_rdy;
  assign taken  = id_cmp_equal ? (a_val == b_val) : (a_val != b_val);
  // The ID slot during REDIRECT is wrong-path, so it never counts or stalls.
  assign decide = (state != BR_REDIRECT) & br_req & ready;

  assign stall_id       = (state != BR_REDIRECT) & br_req & ~ready & rst_n;
  assign redirect_valid = (state == BR_REDIRECT) & rst_n;
  assign flush_id       = redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= BR_IDLE;
      redirect_pc       <= 32'd0;
      perf_branches     <= '0;
      perf_taken        <= '0;
      perf_stall_cycles <= '0;
    end else if (!ext_stall) begin
      case (state)
        BR_REDIRECT: state <= BR_IDLE;
        default: begin
          if (!br_req) begin
            state <= BR_IDLE;
          end else if (!ready) begin
            state <= BR_WAIT;
          end else if (taken) begin
            state       <= BR_REDIRECT;
            redirect_pc <= br_target(id_pc, id_imm);
          end else begin
            state <= BR_IDLE;
          end
        end
      endcase

      if (decide && (perf_branches != '1))
        perf_branches <= perf_branches + 1'b1;
      if (decide && taken && (perf_taken != '1))
        perf_taken <= perf_taken + 1'b1;
      if (stall_id && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed plus random stimulus against a transaction-level model of the branch resolver.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, ext_stall;
  logic        id_valid, id_is_branch, id_cmp_equal;
  logic [4:0]  id_rs, id_rt, ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic [31:0] id_pc, rf_rdata1, rf_rdata2, mem_result, wb_data;
  logic [15:0] id_imm;
  logic        ex_wr_en, mem_wr_en, wb_wr_en, mem_is_load;

  logic        stall_id, flush_id, redirect_valid;
  logic [31:0] redirect_pc, perf_branches, perf_taken, perf_stall_cycles;
  logic        s_stall, s_flush, s_rv;
  logic [31:0] s_pc;
  logic [2:0]  s_br, s_tk, s_st;

  int passed = 0;
  int total  = 0;

  // Model: only "is the next cycle a redirect" matters externally.
  bit          m_redir;
  logic [31:0] m_pc;
  longint      m_br, m_tk, m_st;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_cmp_equal(id_cmp_equal),
    .id_rs(id_rs), .id_rt(id_rt), .id_pc(id_pc), .id_imm(id_imm),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
    .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg),
    .mem_is_load(mem_is_load), .mem_result(mem_result), .wb_data(wb_data),
    .stall_id(stall_id), .flush_id(flush_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .perf_branches(perf_branches), .perf_taken(perf_taken),
    .perf_stall_cycles(perf_stall_cycles)
  );

  branch_resolve_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_cmp_equal(id_cmp_equal),
    .id_rs(id_rs), .id_rt(id_rt), .id_pc(id_pc), .id_imm(id_imm),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
    .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg),
    .mem_is_load(mem_is_load), .mem_result(mem_result), .wb_data(wb_data),
    .stall_id(s_stall), .flush_id(s_flush), .redirect_valid(s_rv),
    .redirect_pc(s_pc), .perf_branches(s_br), .perf_taken(s_tk),
    .perf_stall_cycles(s_st)
  );

  function automatic void operand(input logic [4:0] r, input logic [31:0] rf,
                                  output logic [31:0] v, output bit rdy);
    v = rf; rdy = 1'b1;
    if (r == 5'd0) v = 32'd0;
    else if (ex_wr_en && ex_wr_reg == r) rdy = 1'b0;
    else if (mem_wr_en && mem_wr_reg == r) begin v = mem_result; rdy = !mem_is_load; end
    else if (wb_wr_en && wb_wr_reg == r) v = wb_data;
  endfunction

  function automatic logic [31:0] sat(input longint c, input longint maxv);
    return (c > maxv) ? maxv[31:0] : c[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic idle_inputs();
    ext_stall = 0; id_valid = 0; id_is_branch = 0; id_cmp_equal = 0;
    id_rs = 0; id_rt = 0; id_pc = 0; id_imm = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    ex_wr_en = 0; mem_wr_en = 0; wb_wr_en = 0; ex_wr_reg = 0; mem_wr_reg = 0;
    wb_wr_reg = 0; mem_is_load = 0; mem_result = 0; wb_data = 0;
  endtask

  task automatic branch(input bit eq, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] pc, input logic [15:0] imm);
    id_valid = 1; id_is_branch = 1; id_cmp_equal = eq; id_rs = rs; id_rt = rt;
    rf_rdata1 = d1; rf_rdata2 = d2; id_pc = pc; id_imm = imm;
  endtask

  // Check outputs for the current cycle, cross the edge, then advance the model.
  task automatic step();
    logic [31:0] a, b;
    bit ra, rb, req, rdy, tk;
    logic [31:0] tgt;
    #1;
    operand(id_rs, rf_rdata1, a, ra);
    operand(id_rt, rf_rdata2, b, rb);
    req = id_valid && id_is_branch;
    rdy = ra && rb;
    tk  = id_cmp_equal ? (a == b) : (a != b);
    tgt = id_pc + 32'd4 + 32'($signed(id_imm)) * 4;
    check("stall_id", {31'd0, stall_id}, {31'd0, rst_n && !m_redir && req && !rdy});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, rst_n && m_redir});
    check("flush_id", {31'd0, flush_id}, {31'd0, rst_n && m_redir});
    check("redirect_pc", redirect_pc, m_pc);
    check("perf_branches", perf_branches, sat(m_br, 64'hFFFF_FFFF));
    check("perf_taken", perf_taken, sat(m_tk, 64'hFFFF_FFFF));
    check("perf_stall_cycles", perf_stall_cycles, sat(m_st, 64'hFFFF_FFFF));
    check("sat_stall_id", {31'd0, s_stall}, {31'd0, stall_id});
    check("sat_branches", {29'd0, s_br}, sat(m_br, 7));
    check("sat_taken", {29'd0, s_tk}, sat(m_tk, 7));
    check("sat_stall_cycles", {29'd0, s_st}, sat(m_st, 7));
    @(posedge clk);
    if (!rst_n) begin
      m_redir = 0; m_pc = 0; m_br = 0; m_tk = 0; m_st = 0;
    end else if (!ext_stall) begin
      if (m_redir) m_redir = 0;
      else if (req && !rdy) m_st++;
      else if (req) begin
        m_br++;
        if (tk) begin m_tk++; m_redir = 1; m_pc = tgt; end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_redir = 0; m_pc = 0; m_br = 0; m_tk = 0; m_st = 0;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    step();
    rst_n = 1;
    step();

    // Taken beq, no hazards: target 0x110 in the following cycle.
    branch(1, 5'd1, 5'd2, 32'h5, 32'h5, 32'h100, 16'h3);
    step();
    idle_inputs();
    step();
    check("beq_target", redirect_pc, 32'h110);
    step();

    // bne with equal operands: counted, not taken, no stall.
    branch(0, 5'd1, 5'd2, 32'h7, 32'h7, 32'h200, 16'h4);
    step();
    idle_inputs();
    step();

    // Load in EX feeding rs: EX, MEM-load, then WB forward.
    branch(1, 5'd3, 5'd4, 32'h0, 32'h9, 32'h300, 16'h1);
    ex_wr_en = 1; ex_wr_reg = 5'd3;
    step();
    ex_wr_en = 0; mem_wr_en = 1; mem_wr_reg = 5'd3; mem_is_load = 1; mem_result = 32'h1;
    step();
    mem_wr_en = 0; mem_is_load = 0; wb_wr_en = 1; wb_wr_reg = 5'd3; wb_data = 32'h9;
    step();
    idle_inputs();
    step();
    check("load_stall_cycles", perf_stall_cycles, 32'd2);

    // ext_stall for 3 cycles while waiting on an EX producer (rs == rt).
    branch(1, 5'd6, 5'd6, 32'h2, 32'h2, 32'h400, 16'h10);
    ex_wr_en = 1; ex_wr_reg = 5'd6;
    step();
    ext_stall = 1;
    repeat (3) step();
    ext_stall = 0; ex_wr_en = 0; mem_wr_en = 1; mem_wr_reg = 5'd6; mem_result = 32'h2;
    step();
    idle_inputs();
    step();

    // Reset while the redirect is being issued.
    branch(1, 5'd1, 5'd2, 32'h8, 32'h8, 32'h500, 16'h2);
    step();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    check("post_reset_pc", redirect_pc, 32'd0);

    // Negative offset wraps below zero.
    branch(1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h10, 16'h8000);
    step();
    idle_inputs();
    step();
    check("wrap_target", redirect_pc, 32'hFFFE_0014);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 9) < 7);
      id_is_branch = ($urandom_range(0, 9) < 7);
      id_cmp_equal = $urandom_range(0, 1);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_pc = $urandom; id_imm = 16'($urandom);
      rf_rdata1 = $urandom_range(0, 2); rf_rdata2 = $urandom_range(0, 2);
      ex_wr_en = ($urandom_range(0, 3) == 0); ex_wr_reg = 5'($urandom_range(0, 3));
      mem_wr_en = ($urandom_range(0, 2) == 0); mem_wr_reg = 5'($urandom_range(0, 3));
      mem_is_load = $urandom_range(0, 1); mem_result = $urandom_range(0, 2);
      wb_wr_en = $urandom_range(0, 1); wb_wr_reg = 5'($urandom_range(0, 3));
      wb_data = $urandom_range(0, 2);
      ext_stall = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
